// File: rtl/imc_result_buffer.sv
// Circular result buffer for IMC ADC rows, read back one BUS_W slice at a time.
// Define IMC_ACCUM_EN to sum ACC_LEN saturating samples per channel before each push.
module imc_result_buffer #(
  parameter int unsigned NUM_ADC   = 16,
  parameter int unsigned ADC_BITS  = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned ACC_LEN   = 4,
  parameter int unsigned ACC_EXTRA = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr,
  input  logic                        imc_valid,
  input  logic [NUM_ADC*ADC_BITS-1:0] imc_data,
  input  logic                        rd_req,
  input  logic [3:0]                  rd_slice,
  input  logic                        rd_pop,
  output logic [BUS_W-1:0]            rd_data,
  output logic                        rd_ack,
  output logic                        full,
  output logic                        empty,
  output logic [ADDR_W:0]             count,
  output logic [31:0]                 status
);

`ifdef IMC_ACCUM_EN
  localparam int unsigned CH_W = ADC_BITS + ACC_EXTRA;
`else
  localparam int unsigned CH_W = ADC_BITS;
`endif
  localparam int unsigned ROW_W  = NUM_ADC * CH_W;
  localparam int unsigned NSLICE = (ROW_W + BUS_W - 1) / BUS_W;
  localparam int unsigned PAD_W  = NSLICE * BUS_W;

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || DEPTH > 128) begin : g_chk_depth
    $error("imc_result_buffer: DEPTH must be 2**ADDR_W within 2..128");
  end
  if (NSLICE > 16) begin : g_chk_nslice
    $error("imc_result_buffer: row needs more than 16 bus slices");
  end
  if (ACC_LEN < 1 || ACC_EXTRA > 16) begin : g_chk_acc
    $error("imc_result_buffer: ACC_LEN must be >= 1 and ACC_EXTRA <= 16");
  end

  logic [ROW_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [BUS_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_ack_q, rd_ack_d;

  logic              push_req;
  logic [ROW_W-1:0]  push_row;
  logic              do_push;
  logic              do_pop;
  logic [PAD_W-1:0]  head_pad;
  logic [BUS_W-1:0]  slice_word;

`ifdef IMC_ACCUM_EN
  localparam int unsigned SMP_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic [ROW_W-1:0] acc_q, acc_d, acc_sum;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [CH_W:0]    ch_sum;

  always_comb begin
    acc_sum  = '0;
    ch_sum   = '0;
    acc_d    = acc_q;
    smp_d    = smp_q;
    push_req = 1'b0;
    // One guard bit per channel detects the carry that triggers saturation.
    for (int unsigned i = 0; i < NUM_ADC; i++) begin
      ch_sum = {1'b0, acc_q[i*CH_W +: CH_W]} + (CH_W+1)'(imc_data[i*ADC_BITS +: ADC_BITS]);
      acc_sum[i*CH_W +: CH_W] = ch_sum[CH_W] ? {CH_W{1'b1}} : ch_sum[CH_W-1:0];
    end
    if (imc_valid) begin
      if (smp_q == SMP_W'(ACC_LEN - 1)) begin
        push_req = 1'b1;
        acc_d    = '0;
        smp_d    = '0;
      end else begin
        acc_d = acc_sum;
        smp_d = smp_q + 1'b1;
      end
    end
  end

  assign push_row = acc_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      smp_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      smp_q <= '0;
    end else begin
      acc_q <= acc_d;
      smp_q <= smp_d;
    end
  end
`else
  assign push_req = imc_valid;
  assign push_row = imc_data;
`endif

  // Full and empty come from the count, so equal pointers are never ambiguous.
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    do_pop   = rd_pop && !empty;
    do_push  = push_req && (!full || do_pop);
    ovf_d    = ovf_q | (push_req && full && !do_pop);
    udf_d    = udf_q | (rd_pop && empty);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    head_pad              = '0;
    head_pad[ROW_W-1:0]   = mem_q[rd_ptr_q];
    slice_word            = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (rd_slice == 4'(s)) slice_word = head_pad[s*BUS_W +: BUS_W];
    end
    rd_ack_d  = rd_req;
    rd_data_d = rd_data_q;
    if (rd_req) rd_data_d = empty ? '0 : slice_word;
  end

  // NOTE: row storage has no reset; pointers and count alone define which rows are live.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_row;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_ack  = rd_ack_q;
  assign status  = {ovf_q, udf_q, full, empty, 4'b0000,
                    8'(count_q), 8'(wr_ptr_q), 8'(rd_ptr_q)};

endmodule

// File: tb/tb_imc_result_buffer.sv
// Directed bench for imc_result_buffer with hand-computed expectations.
// With IMC_ACCUM_EN defined only the accumulate/saturate sequence runs.
module tb_imc_result_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        imc_valid = 1'b0;
  logic [63:0] imc_data = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_slice = '0;
  logic        rd_pop = 1'b0;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic [31:0] status;

  int tests_run = 0;
  int tests_failed = 0;

  imc_result_buffer dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .imc_valid(imc_valid),
    .imc_data(imc_data), .rd_req(rd_req), .rd_slice(rd_slice), .rd_pop(rd_pop),
    .rd_data(rd_data), .rd_ack(rd_ack), .full(full), .empty(empty),
    .count(count), .status(status)
  );

`ifdef IMC_ACCUM_EN
  logic [31:0] sat_rd_data;
  logic        sat_rd_ack;
  logic        sat_full;
  logic        sat_empty;
  logic [4:0]  sat_count;
  logic [31:0] sat_status;

  imc_result_buffer #(.ACC_EXTRA(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .clr(clr), .imc_valid(imc_valid),
    .imc_data(imc_data), .rd_req(rd_req), .rd_slice(rd_slice), .rd_pop(rd_pop),
    .rd_data(sat_rd_data), .rd_ack(sat_rd_ack), .full(sat_full), .empty(sat_empty),
    .count(sat_count), .status(sat_status)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] row(input int k);
    return {32'hA5A5_0000 | 32'(k), 32'h0000_1000 + 32'(k)};
  endfunction

  task automatic push(input logic [63:0] r);
    imc_valid = 1'b1;
    imc_data  = r;
    tick();
    imc_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] s, input logic [31:0] exp);
    rd_req   = 1'b1;
    rd_slice = s;
    tick();
    rd_req   = 1'b0;
    check({tag, "_ack"}, 64'(rd_ack), 64'd1);
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ack", 64'(rd_ack), 64'd0);
    check("rst_status", 64'(status), 64'h1000_0000);
    reset_n = 1'b1;
    tick();

`ifdef IMC_ACCUM_EN
    // ch0 = F, ch1 = 1 each sample; four samples make one row.
    for (int i = 0; i < 3; i++) push(64'h1F);
    check("acc_no_push", 64'(count), 64'd0);
    push(64'h1F);
    check("acc_push", 64'(count), 64'd1);
    check("acc_sat_push", 64'(sat_count), 64'd1);
    rd_req   = 1'b1;
    rd_slice = 4'd0;
    tick();
    rd_req   = 1'b0;
    check("acc_sum", 64'(rd_data), 64'h0000_013C);
    check("acc_sat_sum", 64'(sat_rd_data), 64'h0000_009F);
    check("acc_sat_ack", 64'(sat_rd_ack), 64'd1);
    for (int i = 0; i < 4; i++) push(64'h1F);
    check("acc_second", 64'(count), 64'd2);
    check("acc_ovf", 64'(status[31]), 64'd0);
`else
    // Single row, slice reads and hold behaviour.
    push(64'hFEDC_BA98_7654_3210);
    check("t1_count", 64'(count), 64'd1);
    check("t1_stat_cnt", 64'(status[23:16]), 64'd1);
    read_check("t1_s0", 4'd0, 32'h7654_3210);
    read_check("t1_s2", 4'd2, 32'h0);
    read_check("t1_s15", 4'd15, 32'h0);
    read_check("t1_s1", 4'd1, 32'hFEDC_BA98);
    tick();
    check("t1_idle_ack", 64'(rd_ack), 64'd0);
    check("t1_hold", 64'(rd_data), 64'hFEDC_BA98);
    pulse_clr();
    check("clr_status", 64'(status), 64'h1000_0000);
    check("clr_data", 64'(rd_data), 64'd0);

    // Fill to full.
    for (int k = 0; k < 16; k++) push(row(k));
    check("t2_full", 64'(full), 64'd1);
    check("t2_stat_full", 64'(status[29]), 64'd1);
    check("t2_count", 64'(count), 64'd16);
    check("t2_no_ovf", 64'(status[31]), 64'd0);

    // Push and pop together while full.
    imc_valid = 1'b1;
    imc_data  = row(16);
    rd_pop    = 1'b1;
    tick();
    imc_valid = 1'b0;
    rd_pop    = 1'b0;
    check("t3_count", 64'(count), 64'd16);
    check("t3_no_ovf", 64'(status[31]), 64'd0);
    check("t3_rd_ptr", 64'(status[7:0]), 64'd1);
    check("t3_wr_ptr", 64'(status[15:8]), 64'd1);

    // Push while full with no pop: dropped, overflow sticky.
    push(row(99));
    check("t2_ovf", 64'(status[31]), 64'd1);
    check("t2_ovf_count", 64'(count), 64'd16);
    read_check("t2_head_lo", 4'd0, 32'h0000_1001);
    read_check("t2_head_hi", 4'd1, 32'hA5A5_0001);

    // Drain.
    rd_pop = 1'b1;
    repeat (15) tick();
    rd_pop = 1'b0;
    check("t3_drain_cnt", 64'(count), 64'd1);
    read_check("t3_last_row", 4'd0, 32'h0000_1010);
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    check("t3_empty", 64'(empty), 64'd1);
    check("t3_status", 64'(status), 64'h9000_0101);

    // Underflow and empty reads.
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    check("t4_udf", 64'(status[30]), 64'd1);
    check("t4_count", 64'(count), 64'd0);
    read_check("t4_empty_rd", 4'd0, 32'h0);
    pulse_clr();
    check("t4_clr", 64'(status), 64'h1000_0000);

    // Push and pop together while empty: push only, underflow set.
    imc_valid = 1'b1;
    imc_data  = row(5);
    rd_pop    = 1'b1;
    tick();
    imc_valid = 1'b0;
    rd_pop    = 1'b0;
    check("t4_pp_empty", 64'(status), 64'h4001_0100);
    read_check("t4_pp_head", 4'd0, 32'h0000_1005);

    // Asynchronous reset mid-stream.
    pulse_clr();
    for (int k = 0; k < 5; k++) push(row(k + 40));
    check("t5_count", 64'(count), 64'd5);
    rd_req   = 1'b1;
    rd_slice = 4'd0;
    tick();
    rd_req   = 1'b0;
    check("t5_ack_pre", 64'(rd_ack), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_cnt", 64'(count), 64'd0);
    check("t5_async_empty", 64'(empty), 64'd1);
    check("t5_async_ack", 64'(rd_ack), 64'd0);
    check("t5_async_data", 64'(rd_data), 64'd0);
    #4 reset_n = 1'b1;
    tick();
    check("t5_after", 64'(status), 64'h1000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imc_result_buffer.md
Name: imc_result_buffer

Overview:
- Parametrised result buffer that captures IMC ADC result rows from the SRAM controller into a circular store.
- The store is read by the Wishbone side one BUS_W slice at a time.
- Successor to the fixed 64-bit, 16-deep output buffer. Channel count, ADC width, depth and bus width are generic.
- Adds head-pop FIFO semantics, sticky overflow/underflow flags, a packed status word and a synchronous clear.

Parameters:
- NUM_ADC, 16, number of ADC channels per row.
- ADC_BITS, 4, bits per ADC result.
- DEPTH, 16, rows stored; power of two, 2..128.
- ADDR_W, 4, log2(DEPTH).
- BUS_W, 32, readout slice width.
- ACC_LEN, 4, samples summed per row (used only with IMC_ACCUM_EN).
- ACC_EXTRA, 2, extra bits per channel (used only with IMC_ACCUM_EN).

Ports:
- clk  in  1  common clock
- reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of pointers, count, flags and accumulator
- imc_valid  in  1  one-cycle strobe: imc_data holds a valid ADC row
- imc_data  in  NUM_ADC*ADC_BITS  packed ADC outputs; channel i at [i*ADC_BITS +: ADC_BITS]
- rd_req  in  1  request one slice of the head row
- rd_slice  in  4  slice index into the head row
- rd_pop  in  1  discard the head row
- rd_data  out  BUS_W  returned slice
- rd_ack  out  1  rd_data valid strobe
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDR_W+1  rows held
- status  out  32  packed flag word

Behaviour:
- Row width: CH_W = ADC_BITS, or ADC_BITS+ACC_EXTRA when IMC_ACCUM_EN is defined. ROW_W = NUM_ADC*CH_W. NSLICE = ceil(ROW_W/BUS_W), which must be ≤ 16.
- Reset (async) and clr (sync, highest priority after reset):
  - wr_ptr = rd_ptr = count = 0.
  - overflow = underflow = 0.
  - rd_data = 0, rd_ack = 0.
  - Accumulator and sample counter = 0.
  - empty = 1, full = 0.
  - Storage contents are not reset.
- Push: a push is generated by imc_valid (without accumulate) or by the accumulator completing (with accumulate).
  - Not full: write the row at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
  - Full and no simultaneous pop: the row is dropped and overflow is set (sticky until reset/clr).
- Pop: rd_pop when not empty sets rd_ptr+1 mod DEPTH and count-1. rd_pop when empty is ignored and sets underflow (sticky).
- Simultaneous push and pop:
  - Not empty: both take effect, count unchanged.
  - Full: both take effect, no overflow.
  - Empty: push only, underflow set.
- Read:
  - rd_req in cycle N gives rd_ack=1 in cycle N+1, with rd_data = head_row[rd_slice*BUS_W +: BUS_W]. Bits at or above ROW_W read as 0.
  - rd_slice ≥ NSLICE returns 0 with ack.
  - rd_req while empty returns 0 with ack and does not set underflow.
  - rd_req and rd_pop in the same cycle: the slice comes from the pre-pop head.
  - With no rd_req, rd_ack=0 and rd_data holds its last value.
- Pointer wrap: the pointer rolls from DEPTH-1 to 0; full/empty are distinguished by count, not by pointer equality.
- status fields:
  - [31] overflow
  - [30] underflow
  - [29] full
  - [28] empty
  - [27:24] 0
  - [23:16] count, zero-extended
  - [15:8] wr_ptr, zero-extended
  - [7:0] rd_ptr, zero-extended
- All outputs are registered except full, empty, count and status, which are decoded combinationally from registers.

Optional Feature:
- Macro: IMC_ACCUM_EN.
- Defined:
  - Each imc_valid adds every channel, zero-extended to CH_W, into a per-channel accumulator. Each channel saturates at 2^CH_W-1.
  - A sample counter counts valids. On the ACC_LEN-th valid, the final sum (including that sample) is pushed and the accumulator and counter clear in the same cycle.
  - The overflow rule applies at the push.
- Not defined:
  - Each imc_valid pushes imc_data directly. CH_W = ADC_BITS.
  - No accumulator logic is present; ACC_LEN and ACC_EXTRA are unused.

Test Plan:
- Reset, then push one row 64'hFEDC_BA98_7654_3210 and rd_req slices 0 and 1 → rd_ack one cycle later with 32'h7654_3210, then 32'hFEDC_BA98; rd_slice=2 returns 0; count=1, status[23:16]=1.
- Push 16 distinct rows → full=1, status[29]=1. A 17th imc_valid → row dropped, overflow=1, count stays 16; head still reads row 0.
- Full buffer with imc_valid and rd_pop in the same cycle → count stays 16, no overflow, rd_ptr=1, wr_ptr=1 (wrapped); after 16 pops, empty=1.
- rd_pop on an empty buffer → underflow=1, count=0; rd_req on empty → rd_ack=1 with rd_data=0. clr → both flags 0.
- Assert reset_n low mid-stream with count=5 → count=0, empty=1, rd_ack=0 immediately, without waiting for a clock edge.
- IMC_ACCUM_EN with ACC_LEN=4 and channel 0 fed 4'hF four times → one push after the 4th valid; channel 0 = 6'h3C. Feeding 15 four more times with ACC_EXTRA=1 → saturates at 5'h1F.
